// File: rtl/dsd_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   ST_IDLE/ST_RUN/ST_FIN : FSM state encodings
//   state_t               : FSM state type built on those encodings
//   DEF_WIDTH             : default operand/result width
package dsd_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RUN  = ST_RUN,
        FIN  = ST_FIN
    } state_t;

    localparam int DEF_WIDTH = 8;

endpackage

// File: rtl/serial_subtractor_full_sub_cell.sv
// One-bit subtractor cells.
// half_sub_cell : a, b -> d = a^b, bout = ~a&b
// full_sub_cell : a, b, bin -> d = a^b^bin, bout = borrow out
//   Built from two half-subtractor stages; either stage borrowing
//   produces the outgoing borrow.
module half_sub_cell (
    input  logic a,
    input  logic b,
    output logic d,
    output logic bout
);
    assign d    = a ^ b;
    assign bout = ~a & b;
endmodule

module full_sub_cell (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    logic d1, b1, b2;

    half_sub_cell u_hs1 (.a(a),  .b(b),   .d(d1), .bout(b1));
    half_sub_cell u_hs2 (.a(d1), .b(bin), .d(d),  .bout(b2));

    assign bout = b1 | b2;
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: diff = a_in - b_in, one bit per clock, LSB first.
// Ports:
//   clk, rst   : rising-edge clock, synchronous active-high reset
//   start      : request, sampled only in IDLE; captures a_in/b_in
//   a_in, b_in : minuend / subtrahend
//   diff, bout : registered result and final borrow, updated only on completion
//   busy       : high while an operation is in progress
//   done       : one-cycle pulse, diff/bout valid from this cycle
module serial_subtractor
    import dsd_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             busy,
    output logic             done
);

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   a_sh, b_sh, res_sh;
    logic               br;
    logic [CNT_W-1:0]   cnt;
    logic               d_bit, b_next, last;

    full_sub_cell u_fs (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .bin  (br),
        .d    (d_bit),
        .bout (b_next)
    );

    assign last = (cnt == CNT_W'(WIDTH - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            diff   <= '0;
            bout   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh   <= a_in;
                        b_sh   <= b_in;
                        res_sh <= '0;
                        br     <= 1'b0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                    end
                end
                RUN: begin
                    // Result bits enter at the MSB so after WIDTH steps the
                    // first (LSB) difference bit has reached bit 0.
                    res_sh <= {d_bit, res_sh[WIDTH-1:1]};
                    a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
                    b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
                    br     <= b_next;
                    cnt    <= cnt + CNT_W'(1);
                    if (last) begin
                        diff <= {d_bit, res_sh[WIDTH-1:1]};
                        bout <= b_next;
                        done <= 1'b1;
                        busy <= 1'b0;
                    end
                end
                FIN: begin
                    done <= 1'b0;
                end
                default: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    // 8-bit instance
    logic       start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic [7:0] diff8;
    logic       bout8, busy8, done8;

    // 4-bit instance for the exhaustive back-to-back sweep
    logic       start4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic [3:0] diff4;
    logic       bout4, busy4, done4;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .a_in(a8), .b_in(b8),
        .diff(diff8), .bout(bout8), .busy(busy8), .done(done8)
    );

    serial_subtractor #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .a_in(a4), .b_in(b4),
        .diff(diff4), .bout(bout4), .busy(busy4), .done(done4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: unsigned modulo subtraction, borrow when minuend < subtrahend.
    function automatic logic [8:0] ref_sub8(input int a, input int b);
        logic [7:0] d;
        d = 8'((a - b) & 255);
        return {(a < b) ? 1'b1 : 1'b0, d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one 8-bit operation from IDLE and check latency, result, handshake.
    task automatic run_op8(input int a, input int b, input string tag);
        logic [8:0] e;
        int         n;
        bit         seen;
        e = ref_sub8(a, b);
        a8 = 8'(a); b8 = 8'(b); start8 = 1'b1;
        tick();
        start8 = 1'b0;
        a8 = 8'($urandom);  // operands may change after capture
        b8 = 8'($urandom);
        chk({tag, " busy_after_start"}, 32'(busy8), 32'd1);
        n = 0; seen = 0;
        while (n < 16 && !seen) begin
            tick();
            n++;
            if (done8) seen = 1;
        end
        chk({tag, " done_seen"}, 32'(seen), 32'd1);
        chk({tag, " latency"}, 32'(n), 32'd8);
        chk({tag, " diff"}, 32'(diff8), 32'(e[7:0]));
        chk({tag, " bout"}, 32'(bout8), 32'(e[8]));
        chk({tag, " busy_at_done"}, 32'(busy8), 32'd0);
        tick();
        chk({tag, " done_pulse"}, 32'(done8), 32'd0);
        chk({tag, " diff_hold"}, 32'(diff8), 32'(e[7:0]));
        tick();  // back in IDLE
    endtask

    initial begin
        int         dcount;
        logic [7:0] dval;

        // Reset
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        chk("rst diff", 32'(diff8), 32'd0);
        chk("rst bout", 32'(bout8), 32'd0);
        chk("rst busy", 32'(busy8), 32'd0);
        chk("rst done", 32'(done8), 32'd0);
        tick();

        // Directed cases
        run_op8(5, 3, "5-3");
        run_op8(3, 5, "3-5");
        run_op8(0, 1, "0-1");
        run_op8(170, 170, "eq");
        run_op8(255, 0, "255-0");
        run_op8(0, 255, "0-255");

        // start while busy is ignored
        a8 = 8'd5; b8 = 8'd3; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        dcount = 0; dval = '0;
        for (int c = 1; c <= 20; c++) begin
            if (c == 3) begin
                a8 = 8'd9; b8 = 8'd1; start8 = 1'b1;
            end
            tick();
            if (c == 3) start8 = 1'b0;
            if (done8) begin
                dcount++;
                dval = diff8;
            end
        end
        chk("ign done_count", 32'(dcount), 32'd1);
        chk("ign diff", 32'(dval), 32'd2);
        chk("ign diff_final", 32'(diff8), 32'd2);

        // Reset mid-operation aborts with no done
        a8 = 8'd200; b8 = 8'd100; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort diff", 32'(diff8), 32'd0);
        chk("abort bout", 32'(bout8), 32'd0);
        chk("abort busy", 32'(busy8), 32'd0);
        dcount = 0;
        for (int c = 0; c < 12; c++) begin
            if (done8) dcount++;
            tick();
        end
        chk("abort no_done", 32'(dcount), 32'd0);
        run_op8(200, 100, "200-100");

        // Random 8-bit operations
        for (int i = 0; i < 20; i++) begin
            int ra, rb;
            ra = int'($urandom_range(255, 0));
            rb = int'($urandom_range(255, 0));
            run_op8(ra, rb, "rand");
        end

        // Exhaustive 4-bit sweep, start held so each request lands on the
        // first IDLE cycle after FIN.
        begin
            logic [4:0] expq[$];
            logic [4:0] e;
            int         issued, ndone, last_done, sa, sb;
            issued = 0; ndone = 0; last_done = -1;
            a4 = 4'd0; b4 = 4'd0; start4 = 1'b1;
            for (int cyc = 0; cyc < 256 * 6 + 12; cyc++) begin
                tick();
                if (done4) begin
                    if (expq.size() == 0) begin
                        chk("w4 extra_done", 32'd1, 32'd0);
                    end else begin
                        e = expq.pop_front();
                        chk("w4 diff", 32'(diff4), 32'(e[3:0]));
                        chk("w4 bout", 32'(bout4), 32'(e[4]));
                    end
                    if (last_done >= 0) chk("w4 spacing", 32'(cyc - last_done), 32'd6);
                    last_done = cyc;
                    ndone++;
                end
                if (issued < 256 && (cyc % 6) == 0) begin
                    sa = int'(a4); sb = int'(b4);
                    expq.push_back({(sa < sb) ? 1'b1 : 1'b0, 4'((sa - sb) & 15)});
                    issued++;
                    if (issued < 256) begin
                        a4 = 4'(issued / 16);
                        b4 = 4'(issued % 16);
                    end else begin
                        start4 = 1'b0;
                    end
                end
            end
            chk("w4 done_count", 32'(ndone), 32'd256);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
